// File: rtl/frame_capture_sink.sv
// Frame capture sink: writes one (or successive) W x H frames from a fs/hs pixel stream into a
// byte frame buffer, checks line/frame geometry and source coordinates, and keeps a checksum.
// rst_n is an active-high synchronous reset; the name matches the rest of the codebase.
module frame_capture_sink #(
  parameter int unsigned W  = 32,
  parameter int unsigned H  = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          cont,
  input  logic          fs,
  input  logic          hs,
  input  logic [7:0]    data,
  input  logic [10:0]   hang_cnt_out,
  input  logic [10:0]   lie_cnt_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic [31:0]   checksum,
  output logic          err_line,
  output logic          err_frame,
  output logic          err_coord
);

  typedef enum logic [1:0] {StIdle, StWaitFs, StActive, StDone} state_e;

  localparam logic [10:0]   WCnt   = 11'(W);
  localparam logic [10:0]   HCnt   = 11'(H);
  localparam logic [10:0]   CntMax = 11'h7ff;
  localparam logic [AW-1:0] WAddr  = AW'(W);

  state_e state_q, state_d;

  logic          fs_d, hs_d;
  logic [10:0]   row_q, row_d, col_q, col_d;
  logic [31:0]   acc_q, acc_d;
  logic          err_line_q, err_line_d;
  logic          err_frame_q, err_frame_d;
  logic          err_coord_q, err_coord_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [31:0]   checksum_q, checksum_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic        fs_rise, fs_fall, hs_fall;
  logic        start, in_active, pix_valid, line_close, frame_end;
  logic [10:0] row_base, col_base;

  assign fs_rise = fs & ~fs_d;
  assign fs_fall = ~fs & fs_d;
  assign hs_fall = hs_d & ~hs;

  // Capture begins on the first fs edge seen while waiting, so a frame already in flight is skipped.
  assign start      = (state_q == StWaitFs) & fs_rise;
  assign in_active  = (state_q == StActive);
  assign pix_valid  = (start | in_active) & fs & hs;
  // A line still open when fs drops is closed together with the frame.
  assign line_close = in_active & (hs_fall | (fs_fall & hs_d));
  assign frame_end  = in_active & fs_fall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (arm || cont) state_d = StWaitFs;
      StWaitFs: if (fs_rise) state_d = StActive;
      StActive: if (fs_fall) state_d = StDone;
      StDone:   state_d = (arm || cont) ? StWaitFs : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    busy       = (state_q == StWaitFs) || (state_q == StActive);
    frame_done = (state_q == StDone);
  end

  // Pixel datapath: counters, write port, checksum accumulator and sticky error flags.
  always_comb begin
    // On the capture start cycle the counters and flags read as cleared so that cycle's
    // pixel is handled as (0,0) of a fresh frame.
    row_base    = start ? 11'd0 : row_q;
    col_base    = start ? 11'd0 : col_q;
    row_d       = row_base;
    col_d       = col_base;
    acc_d       = start ? 32'd0 : acc_q;
    err_line_d  = start ? 1'b0 : err_line_q;
    err_frame_d = start ? 1'b0 : err_frame_q;
    err_coord_d = start ? 1'b0 : err_coord_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    checksum_d  = checksum_q;
    frame_cnt_d = frame_cnt_q;

    if (pix_valid) begin
      if ((row_base < HCnt) && (col_base < WCnt)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = AW'(row_base) * WAddr + AW'(col_base);
        wr_data_d = data;
        acc_d     = acc_d + 32'(data);
      end
      if (col_base >= WCnt) err_line_d = 1'b1;
      if (row_base >= HCnt) err_frame_d = 1'b1;
      if ((hang_cnt_out != row_base) || (lie_cnt_out != col_base)) err_coord_d = 1'b1;
      col_d = (col_base == CntMax) ? col_base : col_base + 11'd1;
    end

    if (line_close) begin
      if (col_q != WCnt) err_line_d = 1'b1;
      row_d = (row_q == CntMax) ? row_q : row_q + 11'd1;
      col_d = 11'd0;
    end

    // Line closing above is folded in first, so row_d is the final line count.
    if (frame_end) begin
      if (row_d != HCnt) err_frame_d = 1'b1;
      checksum_d  = acc_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Datapath and edge-detect registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      fs_d        <= 1'b0;
      hs_d        <= 1'b0;
      row_q       <= 11'd0;
      col_q       <= 11'd0;
      acc_q       <= 32'd0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
      err_coord_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      checksum_q  <= 32'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      fs_d        <= fs;
      hs_d        <= hs;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      err_coord_q <= err_coord_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      checksum_q  <= checksum_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign checksum  = checksum_q;
  assign frame_cnt = frame_cnt_q;
  assign err_line  = err_line_q;
  assign err_frame = err_frame_q;
  assign err_coord = err_coord_q;

endmodule

// File: tb/tb_frame_capture_sink.sv
// Bench for frame_capture_sink: directed frames; expected writes, frame results and flags come
// from the frame descriptions (line lengths, corrupted pixel, capture intent).
module tb_frame_capture_sink;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, arm, cont, fs, hs;
  logic [7:0]    data;
  logic [10:0]   hang_cnt_out, lie_cnt_out;
  logic          wr_en, busy, frame_done, err_line, err_frame, err_coord;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [15:0]   frame_cnt;
  logic [31:0]   checksum;

  frame_capture_sink #(.W(W), .H(H), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .cont         (cont),
    .fs           (fs),
    .hs           (hs),
    .data         (data),
    .hang_cnt_out (hang_cnt_out),
    .lie_cnt_out  (lie_cnt_out),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .checksum     (checksum),
    .err_line     (err_line),
    .err_frame    (err_frame),
    .err_coord    (err_coord)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; int dat;} wr_t;
  typedef struct {
    int          cyc;
    logic [31:0] sum;
    logic        el, ef, ec;
    logic [15:0] cnt;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    line_len[64];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    done_pulses = 0;
  int    exp_cnt = 0;
  int    peek_cyc = -1;
  int    peek_addr = 0;
  bit    peek_ec = 1'b0;
  int    rst_chk_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, got, want);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctrl"}, {wr_en, frame_done, busy, err_line, err_frame, err_coord, frame_cnt, wr_data},
        64'd0);
    chk({nm, "_data"}, {checksum, 16'(wr_addr)}, 64'd0);
  endtask

  // Drives one frame: 4 idle cycles (arm optional on the first), then lines of line_len[r] pixels
  // separated by 2-cycle hs gaps. The first pixel coincides with fs rising.
  // end_mode 0: hs gap then fs falls; 1: hs and fs fall together; 2: hs stays high one cycle past fs.
  task automatic send_frame(input int nl, input bit capt_in, input bit do_arm, input int end_mode,
                            input int arm_r, input int rst_r, input int rst_c,
                            input int bad_r, input int bad_c,
                            input int pk_r, input int pk_c, input bit pk_ec);
    bit          capt, el, ef, ec, hit, bad;
    logic [31:0] sum;
    capt = capt_in;
    sum  = 32'd0;
    el   = 1'b0;
    ef   = (nl != H);
    ec   = 1'b0;
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
      rst_n = 1'b0; fs = 1'b0; hs = 1'b0; arm = do_arm && (g == 0);
    end
    for (int r = 0; r < nl; r++) begin
      if (line_len[r] != W) el = 1'b1;
      for (int c = 0; c < line_len[r]; c++) begin
        @(posedge clk); #1;
        hit          = (r == rst_r) && (c == rst_c);
        bad          = (r == bad_r) && (c == bad_c);
        rst_n        = hit;
        arm          = (r == arm_r) && (c == 0);
        fs           = 1'b1;
        hs           = 1'b1;
        data         = 8'(r * W + c);
        hang_cnt_out = 11'(r);
        lie_cnt_out  = 11'(c + (bad ? 1 : 0));
        if (hit) begin
          capt        = 1'b0;
          cont        = 1'b0;
          exp_cnt     = 0;
          rst_chk_cyc = cyc + 1;
        end
        if (bad && capt) ec = 1'b1;
        if (capt && r < H && c < W) begin
          exp_wr.push_back('{cyc + 1, r * W + c, (r * W + c) & 255});
          sum += 32'((r * W + c) & 255);
        end
        if (r == pk_r && c == pk_c) begin
          peek_cyc  = cyc + 1;
          peek_addr = r * W + c;
          peek_ec   = pk_ec;
        end
      end
      if (!(r == nl - 1 && end_mode != 0)) begin
        for (int g = 0; g < 2; g++) begin
          @(posedge clk); #1;
          rst_n = 1'b0; arm = 1'b0; fs = 1'b1; hs = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0; arm = 1'b0; fs = 1'b0; hs = (end_mode == 2);
    if (capt) begin
      exp_cnt++;
      exp_done.push_back('{cyc + 1, sum, el, ef, ec, 16'(exp_cnt)});
    end
    if (end_mode == 2) begin
      @(posedge clk); #1;
      hs = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; arm = 1'b0; cont = 1'b0; fs = 1'b0; hs = 1'b0;
    data = 8'd0; hang_cnt_out = 11'd0; lie_cnt_out = 11'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n       = 1'b0;
    exp_cnt     = 0;
    done_pulses = 0;
    @(negedge clk);
    check_zero("reset");
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // Compare process: every write, every frame_done, plus pinned points requested by the driver.
  always @(negedge clk) begin
    wr_t   e;
    done_t d;
    if (wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_wr_en", 64'(wr_en), 64'd0);
      end else begin
        e = exp_wr.pop_front();
        chk("write", {32'(cyc), 16'(wr_addr), 8'(wr_data)},
            {32'(e.cyc), 16'(e.addr), 8'(e.dat)});
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
      e = exp_wr.pop_front();
      chk("missing_write", 64'(wr_en), 64'd1);
    end

    if (frame_done === 1'b1) begin
      done_pulses++;
      if (exp_done.size() == 0) begin
        chk("unexpected_frame_done", 64'(frame_done), 64'd0);
      end else begin
        d = exp_done.pop_front();
        chk("frame_done_cycle", 64'(cyc), 64'(d.cyc));
        chk("checksum", 64'(checksum), 64'(d.sum));
        chk("frame_cnt", 64'(frame_cnt), 64'(d.cnt));
        chk("err_flags", 64'({err_line, err_frame, err_coord}), 64'({d.el, d.ef, d.ec}));
      end
    end else if (exp_done.size() > 0 && exp_done[0].cyc <= cyc) begin
      d = exp_done.pop_front();
      chk("missing_frame_done", 64'(frame_done), 64'd1);
    end

    if (cyc == peek_cyc) begin
      chk("pinned_write", 64'({wr_en, wr_addr, err_coord}),
          64'({1'b1, AW'(peek_addr), peek_ec}));
    end
    if (cyc == rst_chk_cyc) check_zero("midframe_reset");
  end

  initial begin
    rst_n = 1'b1; arm = 1'b0; cont = 1'b0; fs = 1'b0; hs = 1'b0;
    data = 8'd0; hang_cnt_out = 11'd0; lie_cnt_out = 11'd0;
    for (int i = 0; i < 64; i++) line_len[i] = W;

    // Nominal 32x32 frame.
    do_reset();
    send_frame(32, 1, 1, 0, -1, -1, -1, -1, -1, 31, 31, 0);
    settle();
    chk("nominal_checksum", 64'(checksum), 64'd130560);
    chk("nominal_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("nominal_errs", 64'({err_line, err_frame, err_coord}), 64'd0);
    chk("nominal_idle_busy", 64'(busy), 64'd0);

    // Arm during row 10: that frame is skipped, the next one captured.
    do_reset();
    send_frame(32, 0, 0, 0, 10, -1, -1, -1, -1, -1, -1, 0);
    @(negedge clk);
    chk("midarm_busy", 64'(busy), 64'd1);
    send_frame(32, 1, 0, 0, -1, -1, -1, -1, -1, 0, 0, 0);
    settle();
    chk("midarm_frame_cnt", 64'(frame_cnt), 64'd1);

    // Line 5 short, line 6 long; row 6 must start at address 192.
    line_len[5] = 31;
    line_len[6] = 33;
    send_frame(32, 1, 1, 0, -1, -1, -1, -1, -1, 6, 0, 0);
    settle();
    chk("shortlong_err_line", 64'(err_line), 64'd1);
    line_len[5] = W;
    line_len[6] = W;

    // 31 and 33 lines.
    send_frame(31, 1, 1, 0, -1, -1, -1, -1, -1, -1, -1, 0);
    settle();
    chk("lines31_err_frame", 64'(err_frame), 64'd1);
    send_frame(33, 1, 1, 0, -1, -1, -1, -1, -1, -1, -1, 0);
    settle();
    chk("lines33_err_frame", 64'(err_frame), 64'd1);

    // Column mismatch at (3,7), then flags clear on the next frame.
    send_frame(32, 1, 1, 0, -1, -1, -1, 3, 7, 3, 7, 1);
    settle();
    chk("coord_err_coord", 64'(err_coord), 64'd1);
    send_frame(32, 1, 1, 0, -1, -1, -1, -1, -1, 0, 0, 0);
    settle();
    chk("coord_cleared", 64'({err_line, err_frame, err_coord}), 64'd0);

    // Continuous mode over 3 frames, then reset at row 20 of frame 4.
    do_reset();
    cont = 1'b1;
    send_frame(32, 1, 0, 0, -1, -1, -1, -1, -1, -1, -1, 0);
    send_frame(32, 1, 0, 1, -1, -1, -1, -1, -1, -1, -1, 0);
    send_frame(32, 1, 0, 2, -1, -1, -1, -1, -1, -1, -1, 0);
    settle();
    chk("cont_frame_cnt", 64'(frame_cnt), 64'd3);
    chk("cont_done_pulses", 64'(done_pulses), 64'd3);
    send_frame(32, 1, 0, 0, -1, 20, 5, -1, -1, -1, -1, 0);
    send_frame(32, 0, 0, 0, -1, -1, -1, -1, -1, -1, -1, 0);
    settle();
    chk("post_reset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_done_pulses", 64'(done_pulses), 64'd3);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("frames_outstanding", 64'(exp_done.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
